// File: rtl/glbl_rst_seq.sv
// Per-domain reset release sequencer: staggers active-low domain reset releases,
// lowest index first, with a programmable gap; re-asserts take effect immediately.
module glbl_rst_seq #(
  parameter int unsigned NUM_DOM = 8,
  parameter int unsigned DLY_W   = 8
) (
  input  logic               clk,
  input  logic               e_reset,
  input  logic [31:0]        rst_ctrl,
  input  logic [DLY_W-1:0]   cfg_dly,
  input  logic               soft_rst,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               seq_busy,
  output logic               seq_done
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t             state;
  logic [DLY_W-1:0]   cnt;
  logic [NUM_DOM-1:0] req;
  logic [NUM_DOM-1:0] pending;
  logic [NUM_DOM-1:0] lowest;

  assign req     = rst_ctrl[NUM_DOM-1:0];
  assign pending = req & ~dom_rst_n;
  // Two's-complement trick isolates the lowest set bit of pending.
  assign lowest  = pending & (~pending + NUM_DOM'(1));

  generate
    if (NUM_DOM < 32) begin : g_unused_ctrl
      logic unused_ctrl;
      assign unused_ctrl = ^rst_ctrl[31:NUM_DOM];
    end
  endgenerate

  always_ff @(posedge clk or posedge e_reset) begin
    if (e_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      dom_rst_n <= '0;
      seq_busy  <= 1'b0;
      seq_done  <= 1'b0;
    end else if (soft_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dom_rst_n <= '0;
      seq_busy  <= 1'b0;
      seq_done  <= 1'b0;
    end else begin
      // Withdrawn requests drop their domain back into reset regardless of state.
      dom_rst_n <= dom_rst_n & req;
      seq_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (pending != '0) begin
            cnt      <= cfg_dly;
            state    <= WAIT;
            seq_busy <= 1'b1;
          end
        end
        WAIT: begin
          if (pending == '0) begin
            state    <= IDLE;
            seq_busy <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - DLY_W'(1);
          end else begin
            dom_rst_n <= (dom_rst_n | lowest) & req;
            if ((pending & ~lowest) != '0) begin
              cnt <= cfg_dly;
            end else begin
              state    <= IDLE;
              seq_busy <= 1'b0;
              seq_done <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          seq_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
